// File: rtl/cpu_fetch.sv
// cpu_fetch: instruction fetch stage of the MiniSoC CPU.
// Reads a three-word instruction (opcode, operand A, operand B) over a
// req/ack word bus. It presents the instruction with a one-cycle
// fetch_done_o pulse. It then waits for decode to finish before advancing
// the PC, or before jumping to the PC that decode supplies.
module cpu_fetch #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0,
    parameter logic [WIDTH-1:0] FETCH_STEP = 32'hC
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    output logic             mem_req_o,
    output logic [WIDTH-1:0] mem_addr_o,
    input  logic [WIDTH-1:0] mem_rdata_i,
    input  logic             mem_ack_i,
    output logic [WIDTH-1:0] opcode_o,
    output logic [WIDTH-1:0] opa_o,
    output logic [WIDTH-1:0] opb_o,
    output logic             fetch_done_o,
    input  logic             exec_done_i,
    input  logic             isjcc_i,
    input  logic [WIDTH-1:0] newpc_i,
    output logic [WIDTH-1:0] pc_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        PRESENT   = 2'd2,
        WAIT_EXEC = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       idx_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] stage0_q;
    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] opcode_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] word_addr;

    // The bus sees the PC with its low two bits cleared, plus the word offset.
    // The stored PC keeps any misalignment that a jump target carries.
    assign word_addr = {pc_q[WIDTH-1:2], 2'b00}
                     + {{(WIDTH-4){1'b0}}, idx_q, 2'b00};

    assign opcode_o = opcode_q;
    assign opa_o    = opa_q;
    assign opb_o    = opb_q;
    assign pc_o     = pc_q;

    // State register; reset returns to IDLE without waiting for a clock edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a bus word is only ever left once it is acknowledged
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack_i && (idx_q == 2'd2)) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                state_d = WAIT_EXEC;
            end
            WAIT_EXEC: begin
                if (exec_done_i) begin
                    state_d = enable_i ? REQ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state only, so reset clears them asynchronously
    always_comb begin
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        fetch_done_o = 1'b0;
        unique case (state_q)
            REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = word_addr;
            end
            PRESENT: begin
                fetch_done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath: word capture, the instruction output load and the PC update
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx_q    <= 2'd0;
            pc_q     <= RESET_PC;
            stage0_q <= '0;
            stage1_q <= '0;
            opcode_q <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    idx_q <= 2'd0;
                end
                REQ: begin
                    if (mem_ack_i) begin
                        unique case (idx_q)
                            2'd0: begin
                                stage0_q <= mem_rdata_i;
                                idx_q    <= 2'd1;
                            end
                            2'd1: begin
                                stage1_q <= mem_rdata_i;
                                idx_q    <= 2'd2;
                            end
                            default: begin
                                // The last word goes straight to opb, so all
                                // three outputs change together on PRESENT entry.
                                opcode_q <= stage0_q;
                                opa_q    <= stage1_q;
                                opb_q    <= mem_rdata_i;
                                idx_q    <= 2'd0;
                            end
                        endcase
                    end
                end
                WAIT_EXEC: begin
                    if (exec_done_i) begin
                        pc_q  <= isjcc_i ? newpc_i : (pc_q + FETCH_STEP);
                        idx_q <= 2'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: scoreboard bench for cpu_fetch.
// Memory returns ~address for every word. Expected fetch results and bus
// addresses are queued when the stimulus is issued. Monitors pop and compare
// these entries whenever the DUT completes a bus read or pulses fetch_done_o.
module tb_cpu_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] opcode;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        fetch_done;
    logic        exec_done;
    logic        isjcc;
    logic [31:0] newpc;
    logic [31:0] pc;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int last_mark = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] op;
        logic [31:0] a;
        logic [31:0] b;
        int          gap;
    } fetch_exp_t;

    typedef struct {
        int          stall;
        logic        jump;
        logic [31:0] target;
    } plan_t;

    fetch_exp_t  fetch_q[$];
    logic [31:0] addr_q[$];
    plan_t       plan_q[$];

    int          stall_left = 2;
    logic [31:0] stall_addr = 32'h44;

    cpu_fetch #(
        .WIDTH      (32),
        .RESET_PC   (32'h0),
        .FETCH_STEP (32'hC)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .enable_i     (enable),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_rdata_i  (mem_rdata),
        .mem_ack_i    (mem_ack),
        .opcode_o     (opcode),
        .opa_o        (opa),
        .opb_o        (opb),
        .fetch_done_o (fetch_done),
        .exec_done_i  (exec_done),
        .isjcc_i      (isjcc),
        .newpc_i      (newpc),
        .pc_o         (pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic expect_instr(input logic [31:0] exp_pc, input logic [31:0] op,
                                input logic [31:0] a, input logic [31:0] b, input int gap,
                                input logic [31:0] ad0, input logic [31:0] ad1,
                                input logic [31:0] ad2);
        fetch_exp_t e;
        e.pc  = exp_pc;
        e.op  = op;
        e.a   = a;
        e.b   = b;
        e.gap = gap;
        fetch_q.push_back(e);
        addr_q.push_back(ad0);
        addr_q.push_back(ad1);
        addr_q.push_back(ad2);
    endtask

    task automatic plan_exec(input int stall, input logic jump, input logic [31:0] target);
        plan_t p;
        p.stall  = stall;
        p.jump   = jump;
        p.target = target;
        plan_q.push_back(p);
    endtask

    task automatic wait_addr(input logic [31:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == target) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL wait_addr: address %h never requested, got %h", target, mem_addr);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fetch_q.size() == 0) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL wait_drain: %0d fetches outstanding, expected 0", fetch_q.size());
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_mem_req"},    {31'd0, mem_req},    32'd0);
        check_output({tag, "_mem_addr"},   mem_addr,            32'd0);
        check_output({tag, "_fetch_done"}, {31'd0, fetch_done}, 32'd0);
        check_output({tag, "_opcode"},     opcode,              32'd0);
        check_output({tag, "_opa"},        opa,                 32'd0);
        check_output({tag, "_opb"},        opb,                 32'd0);
        check_output({tag, "_pc"},         pc,                  32'd0);
    endtask

    // Memory model: returns ~addr and holds off the ack on the stalled address
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (mem_addr == stall_addr && stall_left > 0) begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'hBAD0_0000;
                    stall_left--;
                end else begin
                    mem_ack   = 1'b1;
                    mem_rdata = ~mem_addr;
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hBAD0_0000;
            end
        end
    end

    // Decode model: after each pulse, applies the next planned jump and stall
    initial begin
        plan_t p;
        exec_done = 1'b1;
        isjcc     = 1'b0;
        newpc     = 32'hDEAD_BEEC;
        forever begin
            @(negedge clk);
            if (fetch_done) begin
                if (plan_q.size() > 0) begin
                    p = plan_q.pop_front();
                end else begin
                    p.stall  = 0;
                    p.jump   = 1'b0;
                    p.target = 32'h0;
                end
                isjcc = p.jump;
                newpc = p.jump ? p.target : 32'hDEAD_BEEC;
                if (p.stall > 0) begin
                    exec_done = 1'b0;
                    repeat (p.stall + 1) @(negedge clk);
                    exec_done = 1'b1;
                end
            end
        end
    end

    // Bus monitor: every acknowledged read must match the next expected address
    initial begin
        logic [31:0] exp_addr;
        forever begin
            @(negedge clk);
            #1;
            if (mem_req && mem_ack) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL bus_read: got address %h, expected no read", mem_addr);
                end else begin
                    exp_addr = addr_q.pop_front();
                    check_output("bus_addr", mem_addr, exp_addr);
                end
            end
        end
    end

    // Fetch monitor: each pulse is compared with the next expected instruction
    initial begin
        fetch_exp_t e;
        logic       prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (fetch_done) begin
                check_output("fetch_done_single", {31'd0, prev}, 32'd0);
                if (fetch_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL fetch: got pulse at pc %h, expected none", pc);
                end else begin
                    e = fetch_q.pop_front();
                    check_output("fetch_pc",     pc,     e.pc);
                    check_output("fetch_opcode", opcode, e.op);
                    check_output("fetch_opa",    opa,    e.a);
                    check_output("fetch_opb",    opb,    e.b);
                    if (e.gap > 0) begin
                        check_output("fetch_gap", cyc - last_mark, e.gap);
                    end
                end
                last_mark = cyc;
            end
            prev = fetch_done;
        end
    end

    // Watchdog so the bench always ends with a summary
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Directed stimulus
    initial begin
        int req_seen;
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;

        // Linear fetch, unaligned jump, wait states, exec stall and wrap
        expect_instr(32'h0,  32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFF7, 4,
                     32'h0,  32'h4,  32'h8);
        plan_exec(0, 1'b0, 32'h0);
        expect_instr(32'hC,  32'hFFFFFFF3, 32'hFFFFFFEF, 32'hFFFFFFEB, 5,
                     32'hC,  32'h10, 32'h14);
        plan_exec(0, 1'b0, 32'h0);
        expect_instr(32'h18, 32'hFFFFFFE7, 32'hFFFFFFE3, 32'hFFFFFFDF, 5,
                     32'h18, 32'h1C, 32'h20);
        plan_exec(0, 1'b1, 32'h42);
        expect_instr(32'h42, 32'hFFFFFFBF, 32'hFFFFFFBB, 32'hFFFFFFB7, 7,
                     32'h40, 32'h44, 32'h48);
        plan_exec(0, 1'b0, 32'h0);
        expect_instr(32'h4E, 32'hFFFFFFB3, 32'hFFFFFFAF, 32'hFFFFFFAB, 5,
                     32'h4C, 32'h50, 32'h54);
        plan_exec(4, 1'b1, 32'hFFFFFFF4);
        expect_instr(32'hFFFFFFF4, 32'h0000000B, 32'h00000007, 32'h00000003, 9,
                     32'hFFFFFFF4, 32'hFFFFFFF8, 32'hFFFFFFFC);
        plan_exec(0, 1'b0, 32'h0);

        @(negedge clk);
        enable    = 1'b1;
        last_mark = cyc;
        wait_addr(32'hFFFFFFF8, 300);
        enable = 1'b0;
        wait_drain(100);
        repeat (2) @(negedge clk);
        check_output("pc_wrap", pc, 32'h0);
        req_seen = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (mem_req) req_seen++;
        end
        check_output("idle_no_req", req_seen, 0);

        // Restart, then reset in the middle of the next fetch
        expect_instr(32'h0, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFF7, 4,
                     32'h0, 32'h4, 32'h8);
        plan_exec(0, 1'b0, 32'h0);
        addr_q.push_back(32'hC);
        addr_q.push_back(32'h10);
        expect_instr(32'h0, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFF7, 4,
                     32'h0, 32'h4, 32'h8);
        plan_exec(0, 1'b0, 32'h0);

        @(negedge clk);
        enable    = 1'b1;
        last_mark = cyc;
        wait_addr(32'h10, 100);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        #2 rst_n  = 1'b1;
        last_mark = cyc;
        wait_addr(32'h4, 100);
        enable = 1'b0;
        wait_drain(100);
        repeat (8) @(negedge clk);

        check_output("fetch_queue_empty", fetch_q.size(), 0);
        check_output("addr_queue_empty",  addr_q.size(),  0);
        check_output("plan_queue_empty",  plan_q.size(),  0);
        check_output("final_pc", pc, 32'hC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
